lab_vector_sweeper: RTL and testbench

- Parametrised, synthesizable stimulus-and-capture engine for N_IN-input / N_OUT-output combinational lab modules.
- Drives every input combination in order and holds each for HOLD_CYCLES clocks.
- Samples the DUT outputs once per vector, streams each (vector, response) pair out, and compacts all responses into a MISR signature for single-word pass/fail.
- Sits beside the lab DUT on the board/top level and replaces hand-written delay-sequenced stimulus.

---
 rtl/lab_sweep_pkg.sv | 29 ++
 rtl/lab_misr.sv | 35 +++
 rtl/lab_vector_sweeper.sv | 118 +++++++++++
 tb/tb_lab_vector_sweeper.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lab_sweep_pkg.sv
// Shared types and helpers for the lab vector sweeper.
// Holds the sweep state enum and the MISR step function.
package lab_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam int          MISR_MAX_W = 32;

    // One MISR step on a w-bit register held in a 32-bit container.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] din,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    w
    );
        logic [MISR_MAX_W-1:0] r;
        r = (sig << 1) ^ (sig[w-1] ? poly : '0) ^ din;
        if (w < MISR_MAX_W) begin
            r &= (MISR_MAX_W'(1) << w) - MISR_MAX_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/lab_misr.sv
// Multiple-input signature register compacting sampled DUT responses.
// clr has priority over en.
module lab_misr
    import lab_sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign sig_d = SIG_W'(misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(din),
                                    MISR_MAX_W'(POLY), SIG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/lab_vector_sweeper.sv
// Exhaustive stimulus/capture engine for small combinational lab DUTs.
// Define LAB_SWEEP_GRAY_EN to issue vectors in reflected Gray order.
module lab_vector_sweeper
    import lab_sweep_pkg::*;
#(
    parameter int               N_IN        = 3,
    parameter int               N_OUT       = 2,
    parameter int               HOLD_CYCLES = 10,
    parameter int               SIG_W       = 16,
    parameter logic [SIG_W-1:0] POLY        = SIG_W'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] dut_out_i,
    output logic [N_IN-1:0]  vec_o,
    output logic             busy,
    output logic             done,
    output logic             log_valid,
    output logic [N_IN-1:0]  log_vec,
    output logic [N_OUT-1:0] log_out,
    output logic [SIG_W-1:0] signature
);

    localparam int             HW        = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN:0]  CNT_LAST  = {1'b0, {N_IN{1'b1}}};

    state_e           state_q, state_d;
    logic [N_IN:0]    cnt_q, cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             log_valid_q;
    logic [N_IN-1:0]  log_vec_q;
    logic [N_OUT-1:0] log_out_q;
    logic             clr;
    logic             smp;

`ifdef LAB_SWEEP_GRAY_EN
    assign vec_o = cnt_q[N_IN-1:0] ^ (cnt_q[N_IN-1:0] >> 1);
`else
    assign vec_o = cnt_q[N_IN-1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        clr     = 1'b0;
        smp     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    hold_d  = '0;
                    clr     = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    smp    = 1'b1;
                    hold_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            log_valid_q <= 1'b0;
            log_vec_q   <= '0;
            log_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            log_valid_q <= smp;
            if (smp) begin
                log_vec_q <= vec_o;
                log_out_q <= dut_out_i;
            end
        end
    end

    lab_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (smp),
        .din   (SIG_W'(dut_out_i)),
        .sig   (signature)
    );

    assign busy      = (state_q == DRIVE);
    assign done      = (state_q == DONE);
    assign log_valid = log_valid_q;
    assign log_vec   = log_vec_q;
    assign log_out   = log_out_q;

endmodule

// File: tb/tb_lab_vector_sweeper.sv
// Directed self-checking bench for lab_vector_sweeper.
// Honours LAB_SWEEP_GRAY_EN for the expected vector order.
module tb_lab_vector_sweeper;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int HOLD  = 10;
    localparam int SIG_W = 16;
    localparam int NV    = 1 << N_IN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [N_OUT-1:0] dut_out;
    logic [N_IN-1:0]  vec_o;
    logic             busy;
    logic             done;
    logic             log_valid;
    logic [N_IN-1:0]  log_vec;
    logic [N_OUT-1:0] log_out;
    logic [SIG_W-1:0] signature;

    int mode = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [N_IN-1:0] exp_vec(input int k);
        logic [N_IN-1:0] b;
        b = N_IN'(k);
`ifdef LAB_SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Lab DUT: {a^b^c, a&b} with a,b the two upper input bits
    function automatic logic [N_OUT-1:0] resp(input int m,
                                              input logic [N_IN-1:0] v);
        case (m)
            0:       return {^v, v[N_IN-1] & v[N_IN-2]};
            1:       return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [15:0] step(input logic [15:0] s,
                                         input logic [1:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
    endfunction

    always_comb dut_out = resp(mode, vec_o);

    lab_vector_sweeper #(
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .HOLD_CYCLES (HOLD),
        .SIG_W       (SIG_W),
        .POLY        (16'h1021)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dut_out_i (dut_out),
        .vec_o     (vec_o),
        .busy      (busy),
        .done      (done),
        .log_valid (log_valid),
        .log_vec   (log_vec),
        .log_out   (log_out),
        .signature (signature)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic run_sweep(input int m, input int poke);
        logic [15:0]     sig;
        logic [N_IN-1:0] prev;
        int k;
        int e;
        sig  = '0;
        prev = '0;
        k    = 0;
        mode = m;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_up", busy, 1);
        chk("done_clr", done, 0);
        chk("vec_init", vec_o, 0);
        chk("sig_clr", signature, 0);
        for (e = 1; e <= NV * HOLD + HOLD; e++) begin
            if (e == poke) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (log_valid) begin
                chk("log_time", e, (k + 1) * HOLD);
                chk("log_vec", log_vec, exp_vec(k));
                chk("log_out", log_out, resp(m, exp_vec(k)));
`ifdef LAB_SWEEP_GRAY_EN
                if (k > 0) chk("gray_step", $countones(log_vec ^ prev), 1);
`endif
                prev = log_vec;
                sig = step(sig, resp(m, exp_vec(k)));
                k++;
                if (k < NV) chk("vec_next", vec_o, exp_vec(k));
            end
            if (done) break;
        end
        chk("n_logs", k, NV);
        chk("done_time", e, NV * HOLD);
        chk("busy_end", busy, 0);
        chk("done_set", done, 1);
        chk("sig_final", signature, sig);
        chk("vec_hold", vec_o, exp_vec(NV - 1));
    endtask

    initial begin
        logic [15:0] s;
        int pulses;

        #2;
        chk("rst_out", {vec_o, busy, done, log_valid, log_vec, log_out,
                        signature}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_sweep(0, 0);
        repeat (5) @(posedge clk);
        #1 chk("done_sticky", done, 1);

        run_sweep(1, 0);
        chk("sig_zero", signature, 0);

        run_sweep(2, 25);

        mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_nolog", log_valid, 0);
        s = '0;
        for (int k = 0; k < 4; k++) s = step(s, resp(0, exp_vec(k)));
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (log_valid) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        chk("abort_sigfrz", signature, s);
        run_sweep(0, 0);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 1);
        chk("sa_done", done, 0);
        chk("sa_vec", vec_o, 0);

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {vec_o, busy, done, log_valid, log_vec, log_out,
                           signature}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rst_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
